// File: rtl/lc_port_arbiter.sv
// Two-requester round-robin arbiter in front of a lower-level cache.
// Read responses return in order, routed by a FIFO of requester IDs.
module lc_port_arbiter #(
  parameter int PADDR_BITS      = 22,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_N_in,
  input  logic                            req0_valid_in,
  input  logic [PADDR_BITS-1:0]           req0_addr_in,
  input  logic [63:0]                     req0_value_in,
  input  logic                            req0_we_in,
  output logic                            req0_ready_out,
  output logic                            resp0_valid_out,
  input  logic                            resp0_ready_in,
  output logic [PADDR_BITS-1:0]           resp0_addr_out,
  output logic [63:0]                     resp0_value_out,
  input  logic                            req1_valid_in,
  input  logic [PADDR_BITS-1:0]           req1_addr_in,
  input  logic [63:0]                     req1_value_in,
  input  logic                            req1_we_in,
  output logic                            req1_ready_out,
  output logic                            resp1_valid_out,
  input  logic                            resp1_ready_in,
  output logic [PADDR_BITS-1:0]           resp1_addr_out,
  output logic [63:0]                     resp1_value_out,
  output logic                            lc_valid_out,
  output logic [PADDR_BITS-1:0]           lc_addr_out,
  output logic [63:0]                     lc_value_out,
  output logic                            lc_we_out,
  input  logic                            lc_ready_in,
  input  logic                            lc_valid_in,
  input  logic [PADDR_BITS-1:0]           lc_addr_in,
  input  logic [63:0]                     lc_value_in,
  output logic                            lc_ready_out,
  output logic                            dbg_state_out,
  output logic [$clog2(MAX_OUTSTANDING):0] dbg_count_out
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUTSTANDING);

  // Valid/ready: a transfer happens on any rising edge where both are high;
  // valid holds its payload stable until that edge.
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                r_state, w_next_state;
  logic [PADDR_BITS-1:0] r_addr;
  logic [63:0]           r_value;
  logic                  r_we;
  logic                  r_id;
  logic                  r_prio;
  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [PTR_W:0]        r_count;

  logic w_full, w_empty, w_head;
  logic w_elig0, w_elig1, w_gnt0, w_gnt1;
  logic w_lc_hs, w_push, w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];

  // Writebacks never occupy a FIFO slot, so they stay eligible when full.
  assign w_elig0 = req0_valid_in & (req0_we_in | ~w_full);
  assign w_elig1 = req1_valid_in & (req1_we_in | ~w_full);

  always_comb begin
    w_next_state = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_N_in) begin
          if (!r_prio) begin
            w_gnt0 = w_elig0;
            w_gnt1 = w_elig1 & ~w_elig0;
          end else begin
            w_gnt1 = w_elig1;
            w_gnt0 = w_elig0 & ~w_elig1;
          end
        end
        if (w_gnt0 | w_gnt1) w_next_state = ISSUE;
      end
      ISSUE: begin
        if (lc_ready_in) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_lc_hs = (r_state == ISSUE) & lc_ready_in;
  assign w_push  = w_lc_hs & ~r_we;
  assign w_pop   = lc_valid_in & lc_ready_out;

  assign req0_ready_out  = w_gnt0;
  assign req1_ready_out  = w_gnt1;
  assign lc_valid_out    = (r_state == ISSUE);
  assign lc_addr_out     = r_addr;
  assign lc_value_out    = r_value;
  assign lc_we_out       = r_we;
  assign lc_ready_out    = ~w_empty & (w_head ? resp1_ready_in : resp0_ready_in);
  assign resp0_valid_out = lc_valid_in & ~w_empty & ~w_head;
  assign resp1_valid_out = lc_valid_in & ~w_empty & w_head;
  // Response data is a pass-through, forced to zero only while reset is held.
  assign resp0_addr_out  = rst_N_in ? lc_addr_in : '0;
  assign resp1_addr_out  = rst_N_in ? lc_addr_in : '0;
  assign resp0_value_out = rst_N_in ? lc_value_in : '0;
  assign resp1_value_out = rst_N_in ? lc_value_in : '0;
  assign dbg_state_out   = r_state;
  assign dbg_count_out   = r_count;

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_value <= '0;
      r_we    <= 1'b0;
      r_id    <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_gnt0) begin
        r_addr  <= req0_addr_in;
        r_value <= req0_value_in;
        r_we    <= req0_we_in;
        r_id    <= 1'b0;
      end else if (w_gnt1) begin
        r_addr  <= req1_addr_in;
        r_value <= req1_value_in;
        r_we    <= req1_we_in;
        r_id    <= 1'b1;
      end
      if (w_lc_hs) r_prio <= ~r_id;
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_fifo  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= r_id;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_lc_port_arbiter.sv
// Bench for lc_port_arbiter: vector table, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_lc_port_arbiter;
  localparam int PA   = 22;
  localparam int MAXO = 4;

  logic          clk_in = 1'b0;
  logic          rst_N_in;
  logic          req0_valid_in, req0_we_in, req0_ready_out;
  logic [PA-1:0] req0_addr_in;
  logic [63:0]   req0_value_in;
  logic          resp0_valid_out, resp0_ready_in;
  logic [PA-1:0] resp0_addr_out;
  logic [63:0]   resp0_value_out;
  logic          req1_valid_in, req1_we_in, req1_ready_out;
  logic [PA-1:0] req1_addr_in;
  logic [63:0]   req1_value_in;
  logic          resp1_valid_out, resp1_ready_in;
  logic [PA-1:0] resp1_addr_out;
  logic [63:0]   resp1_value_out;
  logic          lc_valid_out, lc_we_out, lc_ready_in;
  logic [PA-1:0] lc_addr_out;
  logic [63:0]   lc_value_out;
  logic          lc_valid_in, lc_ready_out;
  logic [PA-1:0] lc_addr_in;
  logic [63:0]   lc_value_in;
  logic          dbg_state_out;
  logic [2:0]    dbg_count_out;

  lc_port_arbiter #(.PADDR_BITS(PA), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .req0_valid_in(req0_valid_in), .req0_addr_in(req0_addr_in),
    .req0_value_in(req0_value_in), .req0_we_in(req0_we_in),
    .req0_ready_out(req0_ready_out), .resp0_valid_out(resp0_valid_out),
    .resp0_ready_in(resp0_ready_in), .resp0_addr_out(resp0_addr_out),
    .resp0_value_out(resp0_value_out),
    .req1_valid_in(req1_valid_in), .req1_addr_in(req1_addr_in),
    .req1_value_in(req1_value_in), .req1_we_in(req1_we_in),
    .req1_ready_out(req1_ready_out), .resp1_valid_out(resp1_valid_out),
    .resp1_ready_in(resp1_ready_in), .resp1_addr_out(resp1_addr_out),
    .resp1_value_out(resp1_value_out),
    .lc_valid_out(lc_valid_out), .lc_addr_out(lc_addr_out),
    .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
    .lc_ready_in(lc_ready_in), .lc_valid_in(lc_valid_in),
    .lc_addr_in(lc_addr_in), .lc_value_in(lc_value_in),
    .lc_ready_out(lc_ready_out),
    .dbg_state_out(dbg_state_out), .dbg_count_out(dbg_count_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    req0_valid_in = 0; req0_we_in = 0; req0_addr_in = '0; req0_value_in = '0;
    req1_valid_in = 0; req1_we_in = 0; req1_addr_in = '0; req1_value_in = '0;
    resp0_ready_in = 0; resp1_ready_in = 0;
    lc_ready_in = 0; lc_valid_in = 0; lc_addr_in = '0; lc_value_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_N_in = 0;
    req0_valid_in = 1; req1_valid_in = 1; lc_valid_in = 1; lc_ready_in = 1;
    lc_addr_in = '1; lc_value_in = '1; resp0_ready_in = 1; resp1_ready_in = 1;
    #1;
    chk("rst_req0_ready", 64'(req0_ready_out), 0);
    chk("rst_req1_ready", 64'(req1_ready_out), 0);
    chk("rst_resp0_valid", 64'(resp0_valid_out), 0);
    chk("rst_resp1_valid", 64'(resp1_valid_out), 0);
    chk("rst_lc_valid", 64'(lc_valid_out), 0);
    chk("rst_lc_ready", 64'(lc_ready_out), 0);
    chk("rst_lc_addr", 64'(lc_addr_out), 0);
    chk("rst_lc_value", lc_value_out, 0);
    chk("rst_lc_we", 64'(lc_we_out), 0);
    chk("rst_resp_addr", 64'(resp0_addr_out | resp1_addr_out), 0);
    chk("rst_resp_value", resp0_value_out | resp1_value_out, 0);
    @(negedge clk_in);
    drive_idle();
    rst_N_in = 1;
  endtask

  typedef struct {
    logic v0, v1, we0, we1, lcv;
    logic g0, g1, lcrdy, rv0, rv1;
  } vec_t;
  vec_t tbl[7];

  // reference model state
  bit            m_busy;
  logic [PA-1:0] m_addr;
  logic [63:0]   m_val;
  logic          m_we;
  int            m_id, m_prio;

  initial begin
    rst_N_in = 0;
    drive_idle();
    // Idle with empty FIFO and requester 0 holding priority.
    tbl[0] = '{0,0,0,0,0, 0,0,0,0,0};
    tbl[1] = '{1,0,0,0,0, 1,0,0,0,0};
    tbl[2] = '{0,1,0,0,0, 0,1,0,0,0};
    tbl[3] = '{1,1,0,0,0, 1,0,0,0,0};
    tbl[4] = '{1,1,1,1,0, 1,0,0,0,0};
    tbl[5] = '{0,1,0,1,0, 0,1,0,0,0};
    tbl[6] = '{0,0,0,0,1, 0,0,0,0,0};
    do_reset();

    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      req0_valid_in = tbl[i].v0; req1_valid_in = tbl[i].v1;
      req0_we_in = tbl[i].we0; req1_we_in = tbl[i].we1;
      lc_valid_in = tbl[i].lcv; resp0_ready_in = 1; resp1_ready_in = 1;
      #1;
      chk("tbl_g0", 64'(req0_ready_out), 64'(tbl[i].g0));
      chk("tbl_g1", 64'(req1_ready_out), 64'(tbl[i].g1));
      chk("tbl_lcrdy", 64'(lc_ready_out), 64'(tbl[i].lcrdy));
      chk("tbl_rv0", 64'(resp0_valid_out), 64'(tbl[i].rv0));
      chk("tbl_rv1", 64'(resp1_valid_out), 64'(tbl[i].rv1));
      #1;
      drive_idle();
    end
    @(negedge clk_in); #1;
    chk("tbl_state_idle", 64'(dbg_state_out), 0);
    chk("tbl_count0", 64'(dbg_count_out), 0);

    // ---- single read on requester 1 ----
    @(negedge clk_in);
    req1_valid_in = 1; req1_addr_in = 22'h00A40; lc_ready_in = 1; #1;
    chk("sr_g1", 64'(req1_ready_out), 1);
    chk("sr_g0", 64'(req0_ready_out), 0);
    @(negedge clk_in); req1_valid_in = 0; #1;
    chk("sr_lc_valid", 64'(lc_valid_out), 1);
    chk("sr_lc_addr", 64'(lc_addr_out), 64'h00A40);
    chk("sr_lc_we", 64'(lc_we_out), 0);
    @(negedge clk_in);
    lc_valid_in = 1; lc_addr_in = 22'h00A40; lc_value_in = 64'hDEAD_BEEF; resp1_ready_in = 1; #1;
    chk("sr_lc_valid_drop", 64'(lc_valid_out), 0);
    chk("sr_count1", 64'(dbg_count_out), 1);
    chk("sr_resp1_valid", 64'(resp1_valid_out), 1);
    chk("sr_resp1_value", resp1_value_out, 64'hDEAD_BEEF);
    chk("sr_resp0_valid", 64'(resp0_valid_out), 0);
    chk("sr_lc_ready", 64'(lc_ready_out), 1);
    @(negedge clk_in); drive_idle(); #1;
    chk("sr_count0", 64'(dbg_count_out), 0);

    // ---- contention, then FIFO full ----
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_in);
      if (c == 0) begin
        req0_valid_in = 1; req0_addr_in = 22'h10;
        req1_valid_in = 1; req1_addr_in = 22'h20; lc_ready_in = 1;
      end
      #1;
      chk("ct_g0", 64'(req0_ready_out), 64'(c % 4 == 0));
      chk("ct_g1", 64'(req1_ready_out), 64'(c % 4 == 2));
      chk("ct_lc_valid", 64'(lc_valid_out), 64'(c % 2 == 1));
      if (c % 2 == 1) chk("ct_lc_addr", 64'(lc_addr_out), (c % 4 == 1) ? 64'h10 : 64'h20);
    end
    @(negedge clk_in);
    req0_valid_in = 1; req0_we_in = 1; req0_addr_in = 22'h3F0;
    req1_valid_in = 1; req1_we_in = 0; req1_addr_in = 22'h5; #1;
    chk("ff_count4", 64'(dbg_count_out), 4);
    chk("ff_wb_g0", 64'(req0_ready_out), 1);
    chk("ff_rd_g1", 64'(req1_ready_out), 0);
    @(negedge clk_in); req0_valid_in = 0; #1;
    chk("ff_wb_lc_valid", 64'(lc_valid_out), 1);
    chk("ff_wb_lc_we", 64'(lc_we_out), 1);
    chk("ff_wb_lc_addr", 64'(lc_addr_out), 64'h3F0);
    @(negedge clk_in); #1;
    chk("ff_wb_nopush", 64'(dbg_count_out), 4);
    chk("ff_rd_stall", 64'(req1_ready_out), 0);
    @(negedge clk_in); lc_valid_in = 1; lc_value_in = 64'hA; resp0_ready_in = 1; #1;
    chk("ff_pop_resp0", 64'(resp0_valid_out), 1);
    chk("ff_pop_lcrdy", 64'(lc_ready_out), 1);
    chk("ff_rd_stall2", 64'(req1_ready_out), 0);
    @(negedge clk_in); lc_valid_in = 0; #1;
    chk("ff_count3", 64'(dbg_count_out), 3);
    chk("ff_rd_grant", 64'(req1_ready_out), 1);
    do_reset();

    // ---- in-order routing with response backpressure ----
    @(negedge clk_in); req0_valid_in = 1; req0_addr_in = 22'h100; lc_ready_in = 1; #1;
    chk("io_g0", 64'(req0_ready_out), 1);
    @(negedge clk_in); req0_valid_in = 0; #1;
    chk("io_addr0", 64'(lc_addr_out), 64'h100);
    @(negedge clk_in); req1_valid_in = 1; req1_addr_in = 22'h200; #1;
    chk("io_g1", 64'(req1_ready_out), 1);
    @(negedge clk_in); req1_valid_in = 0; #1;
    chk("io_addr1", 64'(lc_addr_out), 64'h200);
    @(negedge clk_in);
    lc_ready_in = 0; lc_valid_in = 1; lc_value_in = 64'h111; resp0_ready_in = 0; resp1_ready_in = 1; #1;
    chk("io_count2", 64'(dbg_count_out), 2);
    chk("io_lcrdy_hold", 64'(lc_ready_out), 0);
    chk("io_resp0_valid", 64'(resp0_valid_out), 1);
    chk("io_resp1_quiet", 64'(resp1_valid_out), 0);
    @(negedge clk_in); #1;
    chk("io_lcrdy_hold2", 64'(lc_ready_out), 0);
    chk("io_count2b", 64'(dbg_count_out), 2);
    @(negedge clk_in); resp0_ready_in = 1; #1;
    chk("io_lcrdy0", 64'(lc_ready_out), 1);
    chk("io_resp0_value", resp0_value_out, 64'h111);
    @(negedge clk_in); lc_value_in = 64'h222; #1;
    chk("io_resp1_valid", 64'(resp1_valid_out), 1);
    chk("io_resp0_quiet", 64'(resp0_valid_out), 0);
    chk("io_resp1_value", resp1_value_out, 64'h222);
    chk("io_lcrdy1", 64'(lc_ready_out), 1);
    @(negedge clk_in); lc_valid_in = 0; #1;
    chk("io_count0", 64'(dbg_count_out), 0);
    do_reset();

    // ---- lower-cache backpressure, then push and pop together ----
    @(negedge clk_in);
    req0_valid_in = 1; req0_addr_in = 22'h2AAAA; req0_value_in = 64'h1234_5678_9ABC_DEF0; #1;
    chk("bp_g0", 64'(req0_ready_out), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      if (k == 0) begin
        req0_valid_in = 0; req0_addr_in = '0; req0_value_in = '0;
      end
      #1;
      chk("bp_valid", 64'(lc_valid_out), 1);
      chk("bp_addr", 64'(lc_addr_out), 64'h2AAAA);
      chk("bp_value", lc_value_out, 64'h1234_5678_9ABC_DEF0);
    end
    @(negedge clk_in); lc_ready_in = 1; req1_valid_in = 1; req1_addr_in = 22'h77; #1;
    chk("bp_valid_hs", 64'(lc_valid_out), 1);
    chk("bp_no_grant_issue", 64'(req1_ready_out), 0);
    @(negedge clk_in); #1;
    chk("pp_count1", 64'(dbg_count_out), 1);
    chk("pp_g1", 64'(req1_ready_out), 1);
    @(negedge clk_in);
    req1_valid_in = 0; lc_valid_in = 1; lc_value_in = 64'h333; resp0_ready_in = 1; #1;
    chk("pp_issue", 64'(lc_valid_out), 1);
    chk("pp_resp0", 64'(resp0_valid_out), 1);
    chk("pp_lcrdy", 64'(lc_ready_out), 1);
    @(negedge clk_in); lc_value_in = 64'h444; resp1_ready_in = 1; #1;
    chk("pp_count_same", 64'(dbg_count_out), 1);
    chk("pp_resp1", 64'(resp1_valid_out), 1);
    chk("pp_resp0_quiet", 64'(resp0_valid_out), 0);
    @(negedge clk_in); lc_valid_in = 0; #1;
    chk("pp_count0", 64'(dbg_count_out), 0);
    do_reset();

    // ---- reset asserted mid-issue ----
    @(negedge clk_in); req0_valid_in = 1; req0_addr_in = 22'h50; lc_ready_in = 1; #1;
    chk("mr_g0", 64'(req0_ready_out), 1);
    @(negedge clk_in); req0_valid_in = 0;
    @(negedge clk_in); lc_ready_in = 0; req1_valid_in = 1; req1_addr_in = 22'h99; #1;
    chk("mr_g1", 64'(req1_ready_out), 1);
    @(negedge clk_in); req0_valid_in = 1; req0_addr_in = 22'h66; #1;
    chk("mr_issue", 64'(lc_valid_out), 1);
    #2; rst_N_in = 0; #1;
    chk("mr_lc_valid_now", 64'(lc_valid_out), 0);
    chk("mr_lc_addr_now", 64'(lc_addr_out), 0);
    chk("mr_ready_now", 64'(req0_ready_out | req1_ready_out), 0);
    chk("mr_count_now", 64'(dbg_count_out), 0);
    @(negedge clk_in);
    @(negedge clk_in); rst_N_in = 1; lc_ready_in = 1; #1;
    chk("mr_first_g0", 64'(req0_ready_out), 1);
    chk("mr_first_g1", 64'(req1_ready_out), 0);
    @(negedge clk_in); req0_valid_in = 0; req1_valid_in = 0; #1;
    chk("mr_new_addr", 64'(lc_addr_out), 64'h66);
    do_reset();

    // ---- randomized traffic against the reference model ----
    m_busy = 0; m_prio = 0; exp_q.delete();
    for (int c = 0; c < 2000; c++) begin
      bit full, e0, e1, do_pop, erdy;
      int g, h;
      @(negedge clk_in);
      req0_valid_in = ($urandom_range(0, 99) < 60);
      req0_we_in    = ($urandom_range(0, 3) == 0);
      req0_addr_in  = PA'($urandom);
      req0_value_in = {$urandom, $urandom};
      req1_valid_in = ($urandom_range(0, 99) < 60);
      req1_we_in    = ($urandom_range(0, 3) == 0);
      req1_addr_in  = PA'($urandom);
      req1_value_in = {$urandom, $urandom};
      lc_ready_in    = 1'($urandom_range(0, 1));
      lc_valid_in    = ($urandom_range(0, 99) < 40);
      lc_addr_in     = PA'($urandom);
      lc_value_in    = {$urandom, $urandom};
      resp0_ready_in = ($urandom_range(0, 99) < 70);
      resp1_ready_in = ($urandom_range(0, 99) < 70);
      #1;
      full = (exp_q.size() == MAXO);
      e0 = req0_valid_in && (req0_we_in || !full);
      e1 = req1_valid_in && (req1_we_in || !full);
      g = -1;
      if (!m_busy) begin
        if (m_prio == 0) g = e0 ? 0 : (e1 ? 1 : -1);
        else             g = e1 ? 1 : (e0 ? 0 : -1);
      end
      chk("rnd_g0", 64'(req0_ready_out), 64'(g == 0));
      chk("rnd_g1", 64'(req1_ready_out), 64'(g == 1));
      chk("rnd_lc_valid", 64'(lc_valid_out), 64'(m_busy));
      if (m_busy) begin
        chk("rnd_lc_addr", 64'(lc_addr_out), 64'(m_addr));
        chk("rnd_lc_value", lc_value_out, m_val);
        chk("rnd_lc_we", 64'(lc_we_out), 64'(m_we));
      end
      h = (exp_q.size() > 0) ? int'(exp_q[0]) : -1;
      erdy = (h == 0) ? resp0_ready_in : ((h == 1) ? resp1_ready_in : 1'b0);
      chk("rnd_resp0_valid", 64'(resp0_valid_out), 64'(lc_valid_in && h == 0));
      chk("rnd_resp1_valid", 64'(resp1_valid_out), 64'(lc_valid_in && h == 1));
      chk("rnd_lc_ready", 64'(lc_ready_out), 64'(erdy));
      if (h == 0) chk("rnd_resp0_value", resp0_value_out, lc_value_in);
      if (h == 1) chk("rnd_resp1_addr", 64'(resp1_addr_out), 64'(lc_addr_in));
      chk("rnd_count", 64'(dbg_count_out), 64'(exp_q.size()));
      do_pop = lc_valid_in && erdy;
      if (do_pop) void'(exp_q.pop_front());
      if (m_busy && lc_ready_in) begin
        if (!m_we) exp_q.push_back(1'(m_id));
        m_prio = 1 - m_id;
        m_busy = 0;
      end
      if (g == 0) begin
        m_busy = 1; m_id = 0; m_addr = req0_addr_in; m_val = req0_value_in; m_we = req0_we_in;
      end else if (g == 1) begin
        m_busy = 1; m_id = 1; m_addr = req1_addr_in; m_val = req1_value_in; m_we = req1_we_in;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/lc_port_arbiter.md
LC_PORT_ARBITER -- requirements
Module: lc_port_arbiter

Interface
REQ-001 SHALL have parameter PADDR_BITS, default 22, physical address width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the read-response routing FIFO (power of 2, >=2).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk_in input 1, sole clock, rising edge; rst_N_in input 1, asynchronous active-low reset.
REQ-004 SHALL have, for each requester n in {0 = L1I, 1 = L1D}, request inputs: reqn_valid_in 1; reqn_addr_in PADDR_BITS; reqn_value_in 64; reqn_we_in 1 (1 = writeback, no response expected).
REQ-005 SHALL have, for each requester n, reqn_ready_out output 1: request accepted this cycle.
REQ-006 SHALL have, for each requester n, response signals: respn_valid_out output 1; respn_ready_in input 1; respn_addr_out output PADDR_BITS; respn_value_out output 64.
REQ-007 SHALL have lower-cache request outputs lc_valid_out 1, lc_addr_out PADDR_BITS, lc_value_out 64 and lc_we_out 1, plus input lc_ready_in 1.
REQ-008 SHALL have lower-cache response inputs lc_valid_in 1, lc_addr_in PADDR_BITS and lc_value_in 64, plus output lc_ready_out 1.

Function
REQ-009 SHALL implement FSM states IDLE and ISSUE.
REQ-010 In IDLE, SHALL grant at most one eligible requester, via reqn_ready_out, asserted combinationally in the same cycle as reqn_valid_in.
- A read is eligible only if the FIFO is not full.
- A writeback is always eligible.
REQ-011 Arbitration SHALL be round-robin: priority goes to the requester not granted last; after reset, requester 0 has priority.
REQ-012 On grant, SHALL register addr, value, we and requester ID, and go to ISSUE next cycle.
REQ-013 In ISSUE:
- lc_valid_out = 1 with the registered fields, held stable until lc_ready_in = 1.
- On the handshake cycle, return to IDLE and update the round-robin pointer.
- No reqn_ready_out is asserted in ISSUE.
REQ-014 Minimum request latency SHALL be 1 cycle from reqn handshake to lc_valid_out, so one request can issue every 2 cycles.
REQ-015 On an lc handshake with we = 0, SHALL push the requester ID into the FIFO; writebacks SHALL NOT push.
REQ-016 Responses SHALL be routed in order to the requester at the FIFO head (h), combinationally:
- resph_valid_out = lc_valid_in AND FIFO not empty.
- resph_addr_out and resph_value_out = lc_addr_in and lc_value_in.
- The other requester's resp valid = 0.
REQ-017 lc_ready_out SHALL equal (FIFO not empty) AND resph_ready_in.
REQ-018 The FIFO SHALL pop on an lc_valid_in and lc_ready_out handshake.
REQ-019 FIFO boundary behaviour:
- Simultaneous push and pop SHALL leave the occupancy count unchanged.
- Pointers wrap modulo MAX_OUTSTANDING.
- The count is ceil(log2(MAX_OUTSTANDING))+1 bits, range 0..MAX_OUTSTANDING.
REQ-020 When the FIFO is empty, SHALL hold lc_ready_out = 0 and all respn_valid_out = 0, whatever lc_valid_in is.
REQ-021 When the FIFO is full, SHALL not grant reads; a pending writeback from either requester SHALL still be granted.
REQ-022 If both requesters are valid but only one is eligible, SHALL grant the eligible one and leave the round-robin pointer to update per REQ-013.
REQ-023 Response return SHALL proceed independently of the FSM state: a response may be delivered in the same cycle as a request grant or issue.

Reset
REQ-024 On rst_N_in = 0, SHALL immediately, without waiting for a clock edge, set:
- FSM to IDLE, FIFO count and pointers to 0, priority to requester 0.
- All registered request fields to 0.
REQ-025 While in reset, all outputs SHALL be 0: lc_valid_out, lc_ready_out, reqn_ready_out, respn_valid_out, and all addr/value/we outputs.
REQ-026 A reset asserted mid-ISSUE SHALL drop the in-flight request and all FIFO entries without issuing to the lower cache.

Verification
REQ-027 Single read: req1 read addr 0x00A40, lc_ready_in = 1 -> req1_ready_out cycle 0, lc_valid_out cycle 1 with addr 0x00A40 and we 0; lc_valid_in with value 0xDEAD_BEEF -> resp1_valid_out = 1 and resp1_value_out = 0xDEAD_BEEF, FIFO empty afterwards.
REQ-028 Contention: both requesters continuously request reads, lc_ready_in = 1 -> grant order 0,1,0,1, each lc issue 2 cycles apart.
REQ-029 FIFO full: 4 reads issued with no responses; a 5th read and a req0 writeback are presented together -> the writeback is granted, issued with lc_we_out = 1, and the read stalls; 1 response is popped -> the read is granted.
REQ-030 In-order routing: reads issued as req0 0x100 then req1 0x200, and resp0_ready_in = 0 -> lc_ready_out = 0 until resp0_ready_in = 1; the first response goes to resp0, the second to resp1.
REQ-031 Backpressure and simultaneous events: lc_ready_in held 0 for 5 cycles -> lc_addr_out and lc_value_out stay stable; a push and a pop in the same cycle leave the count unchanged.
REQ-032 Reset mid-ISSUE: rst_N_in pulled low between clock edges -> lc_valid_out = 0 immediately; after release, the first grant goes to req0.
